// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and constants for the CPU pipeline-stage registers.
//
// Contents:
//   pipe_state_e    occupancy state of an elastic pipeline stage
//   EXE_MEM_*_W     payload/control widths of the EXE/MEM stage register
//   CTRL_*          bit positions of the side-effect control bits
//   occupancy_of()  converts a stage state to an entry count
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_HALF  = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_e;

  localparam int EXE_MEM_DATA_W = 107;
  localparam int EXE_MEM_CTRL_W = 5;

  localparam int CTRL_MEMREAD  = 0;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_REGWRITE = 2;

  function automatic logic [1:0] occupancy_of(input pipe_state_e s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      PS_HALF: n = 2'd1;
      PS_FULL: n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready channel carrying one pipeline entry (payload + control bits).
//
// Signals:
//   valid  source has an entry this cycle
//   ready  sink accepts the entry this cycle
//   data   DATA_W payload
//   ctrl   CTRL_W side-effect control bits
// Modports:
//   master  drives valid/data/ctrl, receives ready
//   slave   receives valid/data/ctrl, drives ready
interface pipe_stage_skid_if
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = EXE_MEM_DATA_W,
  parameter int CTRL_W = EXE_MEM_CTRL_W
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);

endinterface

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with valid/ready handshake.
//
// Holds up to two entries (main = head, skid = overflow) when SKID != 0 so that
// in_ready comes straight from a flop; with SKID == 0 a single register is used
// and in_ready is combinational from out_ready. A flush kills every held entry
// and the entry offered in the same cycle. A saturating counter records cycles
// where the stage holds an entry that downstream refuses.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_bus     upstream channel (slave): valid/data/ctrl in, ready out
//   out_bus    downstream channel (master): valid/data/ctrl out, ready in
//   flush      synchronous kill of all held entries and this cycle's input
//   occupancy  number of entries held (0..2)
//   stall_cnt  saturating count of out_valid & !out_ready cycles
module pipe_stage_skid
  import cpu_pipe_pkg::*;
#(
  parameter int                DATA_W   = EXE_MEM_DATA_W,
  parameter int                CTRL_W   = EXE_MEM_CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0,
  parameter int                SKID     = 1,
  parameter int                CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_stage_skid_if.slave     in_bus,
  pipe_stage_skid_if.master    out_bus,
  input  logic                 flush,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt
);

  pipe_state_e       state;
  pipe_state_e       state_n;

  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  logic in_ready;
  logic out_valid;
  logic in_fire;
  logic out_fire;

  logic load_main_in;
  logic load_main_skid;
  logic load_skid;
  logic clear_main_ctrl;
  logic kill;

  assign out_valid = (state != PS_EMPTY);
  assign in_fire   = in_bus.valid & in_ready;
  assign out_fire  = out_valid & out_bus.ready;

  assign in_bus.ready  = in_ready;
  assign out_bus.valid = out_valid;
  assign out_bus.data  = main_data;
  // Gate with out_valid so a bubble never exposes stale or unknown control bits.
  assign out_bus.ctrl  = out_valid ? main_ctrl : CTRL_RST;
  assign occupancy     = occupancy_of(state);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PS_EMPTY;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and datapath load strobes; flush overrides every transition.
  always_comb begin
    state_n         = state;
    load_main_in    = 1'b0;
    load_main_skid  = 1'b0;
    load_skid       = 1'b0;
    clear_main_ctrl = 1'b0;
    kill            = 1'b0;
    if (flush) begin
      state_n = PS_EMPTY;
      kill    = 1'b1;
    end else begin
      case (state)
        PS_EMPTY: begin
          if (in_fire) begin
            state_n      = PS_HALF;
            load_main_in = 1'b1;
          end
        end
        PS_HALF: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire && (SKID != 0)) begin
            // Head is stuck downstream; park the new entry behind it.
            state_n   = PS_FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_n         = PS_EMPTY;
            clear_main_ctrl = 1'b1;
          end
        end
        PS_FULL: begin
          if (out_fire) begin
            state_n        = PS_HALF;
            load_main_skid = 1'b1;
          end
        end
        default: state_n = PS_EMPTY;
      endcase
    end
  end

  // Head register. Only control bits are cleared on kill/drain; payload keeps its value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data <= '0;
      main_ctrl <= CTRL_RST;
    end else if (kill) begin
      main_ctrl <= CTRL_RST;
    end else if (load_main_in) begin
      main_data <= in_bus.data;
      main_ctrl <= in_bus.ctrl;
    end else if (load_main_skid) begin
      main_data <= skid_data;
      main_ctrl <= skid_ctrl;
    end else if (clear_main_ctrl) begin
      main_ctrl <= CTRL_RST;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;

      // Overflow entry, only ever read when moving into the head.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          skid_data <= '0;
          skid_ctrl <= CTRL_RST;
        end else if (kill) begin
          skid_ctrl <= CTRL_RST;
        end else if (load_skid) begin
          skid_data <= in_bus.data;
          skid_ctrl <= in_bus.ctrl;
        end
      end

      // Ready is precomputed from the next state so it leaves a flop and has
      // no combinational dependence on out_ready.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (state_n != PS_FULL);
        end
      end

      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign skid_data = '0;
      assign skid_ctrl = CTRL_RST;
      assign in_ready  = ~out_valid | out_bus.ready;
    end
  endgenerate

  // Saturating stall counter, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_bus.ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid.
// dut_a: SKID=1, CNT_W=4. dut_b: SKID=0, CNT_W=16. Both DATA_W=16, CTRL_W=5.
// A queue per DUT holds expected entries pushed on each accepted input and
// popped/compared on each delivered output.
module tb_pipe_stage_skid;

  localparam int DW = 16;
  localparam int CW = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_a;
  logic        flush_b;
  logic [1:0]  occ_a;
  logic [1:0]  occ_b;
  logic [3:0]  stall_a;
  logic [15:0] stall_b;

  int checks = 0;
  int errors = 0;

  logic [DW+CW-1:0] qa[$];
  logic [DW+CW-1:0] qb[$];

  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) ia ();
  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) oa ();
  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) ib ();
  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) ob ();

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST('0), .SKID(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .in_bus(ia), .out_bus(oa), .flush(flush_a),
    .occupancy(occ_a), .stall_cnt(stall_a)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST('0), .SKID(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .in_bus(ib), .out_bus(ob), .flush(flush_b),
    .occupancy(occ_b), .stall_cnt(stall_b)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle inputs carry X payload to show it never reaches the outputs.
  task automatic applyStimulus(input bit sel_b, input logic v, input logic [DW-1:0] d,
                               input logic [CW-1:0] c, input logic rdy, input logic fl);
    if (!sel_b) begin
      ia.valid = v;
      ia.data  = v ? d : 'x;
      ia.ctrl  = v ? c : 'x;
      oa.ready = rdy;
      flush_a  = fl;
    end else begin
      ib.valid = v;
      ib.data  = v ? d : 'x;
      ib.ctrl  = v ? c : 'x;
      ob.ready = rdy;
      flush_b  = fl;
    end
  endtask

  // Scoreboard for dut_a: delivery first, then flush/accept of this cycle.
  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
    end else begin
      if (!oa.valid) checkOutput("a_idle_ctrl", 64'(oa.ctrl), 64'(0));
      if (oa.valid && oa.ready) begin
        checkOutput("a_sb_nonempty", 64'(qa.size() != 0), 64'(1));
        if (qa.size() != 0) checkOutput("a_sb_entry", 64'({oa.ctrl, oa.data}), 64'(qa.pop_front()));
      end
      if (flush_a) qa.delete();
      else if (ia.valid && ia.ready) qa.push_back({ia.ctrl, ia.data});
    end
  end

  // Scoreboard for dut_b.
  always @(negedge clk) begin
    if (rst) begin
      qb.delete();
    end else begin
      if (!ob.valid) checkOutput("b_idle_ctrl", 64'(ob.ctrl), 64'(0));
      checkOutput("b_occ_le1", 64'(occ_b <= 2'd1), 64'(1));
      if (ob.valid && ob.ready) begin
        checkOutput("b_sb_nonempty", 64'(qb.size() != 0), 64'(1));
        if (qb.size() != 0) checkOutput("b_sb_entry", 64'({ob.ctrl, ob.data}), 64'(qb.pop_front()));
      end
      if (flush_b) qb.delete();
      else if (ib.valid && ib.ready) qb.push_back({ib.ctrl, ib.data});
    end
  end

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, '0, '0, 0, 0);
    applyStimulus(1, 0, '0, '0, 0, 0);
    repeat (2) step();

    // Reset state
    checkOutput("rst_a_valid", 64'(oa.valid), 64'(0));
    checkOutput("rst_a_ready", 64'(ia.ready), 64'(1));
    checkOutput("rst_a_ctrl", 64'(oa.ctrl), 64'(0));
    checkOutput("rst_a_data", 64'(oa.data), 64'(0));
    checkOutput("rst_a_occ", 64'(occ_a), 64'(0));
    checkOutput("rst_a_stall", 64'(stall_a), 64'(0));
    checkOutput("rst_b_ready", 64'(ib.ready), 64'(1));
    checkOutput("rst_b_occ", 64'(occ_b), 64'(0));
    rst = 1'b0;
    step();

    // Streaming 1..8 with out_ready high
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 1, DW'(i), CW'(i), 1, 0);
      step();
      checkOutput("t2_valid", 64'(oa.valid), 64'(1));
      checkOutput("t2_data", 64'(oa.data), 64'(i));
      checkOutput("t2_occ", 64'(occ_a), 64'(1));
    end
    applyStimulus(0, 0, '0, '0, 1, 0);
    step();
    checkOutput("t2_drained", 64'(oa.valid), 64'(0));
    checkOutput("t2_occ_end", 64'(occ_a), 64'(0));

    // Backpressure fills the skid; C is refused while full
    applyStimulus(0, 1, 16'h0A0A, 5'd3, 0, 0);
    step();
    checkOutput("t3_occ1", 64'(occ_a), 64'(1));
    checkOutput("t3_ready1", 64'(ia.ready), 64'(1));
    applyStimulus(0, 1, 16'h0B0B, 5'd6, 0, 0);
    step();
    checkOutput("t3_occ2", 64'(occ_a), 64'(2));
    checkOutput("t3_ready0", 64'(ia.ready), 64'(0));
    applyStimulus(0, 1, 16'h0C0C, 5'd9, 0, 0);
    #1;
    checkOutput("t3_c_refused", 64'(ia.ready), 64'(0));
    step();
    checkOutput("t3_hold_data", 64'(oa.data), 64'h0A0A);
    checkOutput("t3_hold_ctrl", 64'(oa.ctrl), 64'd3);
    checkOutput("t3_hold_occ", 64'(occ_a), 64'(2));
    applyStimulus(0, 1, 16'h0C0C, 5'd9, 1, 0);
    step();
    checkOutput("t3_b_data", 64'(oa.data), 64'h0B0B);
    checkOutput("t3_b_occ", 64'(occ_a), 64'(1));
    applyStimulus(0, 0, '0, '0, 1, 0);
    step();
    checkOutput("t3_empty", 64'(oa.valid), 64'(0));
    checkOutput("t3_empty_occ", 64'(occ_a), 64'(0));

    // Flush while full, with C offered
    applyStimulus(0, 1, 16'h1111, 5'h1F, 0, 0);
    step();
    applyStimulus(0, 1, 16'h2222, 5'h1F, 0, 0);
    step();
    checkOutput("t4_full", 64'(occ_a), 64'(2));
    checkOutput("t4_ctrl_ones", 64'(oa.ctrl), 64'h1F);
    applyStimulus(0, 1, 16'h3333, 5'h1F, 0, 1);
    step();
    checkOutput("t4_valid", 64'(oa.valid), 64'(0));
    checkOutput("t4_ctrl", 64'(oa.ctrl), 64'(0));
    checkOutput("t4_occ", 64'(occ_a), 64'(0));
    checkOutput("t4_ready", 64'(ia.ready), 64'(1));
    applyStimulus(0, 0, '0, '0, 1, 0);
    repeat (3) begin
      step();
      checkOutput("t4_no_c", 64'(oa.valid), 64'(0));
    end

    // Flush while half, with concurrent delivery and an acceptable input
    applyStimulus(0, 1, 16'h4444, 5'h15, 0, 0);
    step();
    checkOutput("t4b_occ1", 64'(occ_a), 64'(1));
    applyStimulus(0, 1, 16'h5555, 5'h0A, 1, 1);
    #1;
    checkOutput("t4b_ready", 64'(ia.ready), 64'(1));
    step();
    checkOutput("t4b_valid", 64'(oa.valid), 64'(0));
    checkOutput("t4b_occ", 64'(occ_a), 64'(0));
    applyStimulus(0, 0, '0, '0, 1, 0);
    step();
    checkOutput("t4b_no_e", 64'(oa.valid), 64'(0));

    // Mid-stream reset drops everything immediately
    applyStimulus(0, 1, 16'h6666, 5'd7, 0, 0);
    step();
    applyStimulus(0, 1, 16'h6767, 5'd8, 0, 0);
    step();
    checkOutput("t1_full", 64'(occ_a), 64'(2));
    rst = 1'b1;
    #1;
    checkOutput("t1_valid", 64'(oa.valid), 64'(0));
    checkOutput("t1_ready", 64'(ia.ready), 64'(1));
    checkOutput("t1_ctrl", 64'(oa.ctrl), 64'(0));
    checkOutput("t1_occ", 64'(occ_a), 64'(0));
    checkOutput("t1_stall", 64'(stall_a), 64'(0));
    applyStimulus(0, 0, '0, '0, 0, 0);
    step();
    rst = 1'b0;

    // Stall counter: nothing while empty, then saturate at 15
    repeat (3) step();
    checkOutput("t5_empty_nocount", 64'(stall_a), 64'(0));
    applyStimulus(0, 1, 16'h7777, 5'd2, 0, 0);
    step();
    checkOutput("t5_start", 64'(stall_a), 64'(0));
    applyStimulus(0, 0, '0, '0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      step();
      checkOutput("t5_stall", 64'(stall_a), 64'((k < 15) ? k : 15));
      checkOutput("t5_stable", 64'(oa.data), 64'h7777);
    end
    applyStimulus(0, 0, '0, '0, 1, 0);
    repeat (2) step();
    checkOutput("t5_hold", 64'(stall_a), 64'd15);
    checkOutput("t5_empty", 64'(oa.valid), 64'(0));

    // SKID=0: combinational in_ready follows out_ready
    applyStimulus(1, 1, 16'h0011, 5'd1, 1, 0);
    #1;
    checkOutput("t6_ready_empty", 64'(ib.ready), 64'(1));
    step();
    checkOutput("t6_occ_a", 64'(occ_b), 64'(1));
    checkOutput("t6_data_a", 64'(ob.data), 64'h0011);
    applyStimulus(1, 1, 16'h0022, 5'd2, 0, 0);
    #1;
    checkOutput("t6_ready_low", 64'(ib.ready), 64'(0));
    step();
    checkOutput("t6_hold_data", 64'(ob.data), 64'h0011);
    checkOutput("t6_hold_occ", 64'(occ_b), 64'(1));
    applyStimulus(1, 1, 16'h0022, 5'd2, 1, 0);
    #1;
    checkOutput("t6_ready_high", 64'(ib.ready), 64'(1));
    step();
    checkOutput("t6_data_b", 64'(ob.data), 64'h0022);
    checkOutput("t6_occ_b", 64'(occ_b), 64'(1));
    applyStimulus(1, 0, '0, '0, 1, 0);
    step();
    checkOutput("t6_empty", 64'(occ_b), 64'(0));

    // Nothing left undelivered
    repeat (2) step();
    checkOutput("drain_a", 64'(qa.size()), 64'(0));
    checkOutput("drain_b", 64'(qb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
